// File: rtl/sigmoid_inverse_search_if.sv
// Request/response channel of the sigmoid inverse searcher.
// The master drives requests and accepts results; the slave is the searcher itself.
interface sigmoid_inverse_search_if #(
    parameter int BITS = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_y;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_x;
    logic [BITS-1:0] out_fx;
    logic            out_err;

    modport master (
        output in_valid, in_y, out_ready,
        input  in_ready, out_valid, out_x, out_fx, out_err
    );

    modport slave (
        input  in_valid, in_y, out_ready,
        output in_ready, out_valid, out_x, out_fx, out_err
    );
endinterface

// File: rtl/sigmoid_inverse_search.sv
// Bisection inverse of the piecewise-linear sigmoid: smallest x in [-8, 8) with f(x) >= y.
// Optional macro SIGINV_FASTPATH_EN: out-of-range targets skip the search and finish in one clock.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; in_ready=1
// SEARCH | one bisection step per clock, ITER steps total
// DONE   | result on out_x/out_fx/out_err, held until out_ready
module sigmoid_inverse_search #(
    parameter int BITS = 16,
    parameter int FRAC = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sigmoid_inverse_search_if.slave bus
);
    localparam int ITER = FRAC + 4;
    localparam int CW   = $clog2(ITER);
    localparam int W    = 2 * BITS;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic signed [BITS-1:0] LO0   = BITS'(-(1 << (FRAC + 3)));
    localparam logic signed [BITS-1:0] HI0   = BITS'((1 << (FRAC + 3)) - 1);
    localparam logic signed [BITS-1:0] Y_ONE = BITS'(1 << FRAC);

    localparam logic signed [W-1:0] C_ONE  = W'(1 << FRAC);
    localparam logic signed [W-1:0] C_5    = W'(5 << FRAC);
    localparam logic signed [W-1:0] C_2375 = W'(19 << (FRAC - 3));
    localparam logic signed [W-1:0] C_27   = W'(27 << (FRAC - 5));
    localparam logic signed [W-1:0] C_58   = W'(5 << (FRAC - 3));
    localparam logic signed [W-1:0] C_HALF = W'(1 << (FRAC - 1));
    localparam logic signed [W-1:0] S_32   = W'(1 << (FRAC - 5));
    localparam logic signed [W-1:0] S_8    = W'(1 << (FRAC - 3));
    localparam logic signed [W-1:0] S_4    = W'(1 << (FRAC - 2));

    // Same segment table as the forward evaluator, so results agree bit-exactly.
    function automatic logic signed [BITS-1:0] f_eval(input logic signed [BITS-1:0] x);
        logic signed [W-1:0] a;
        logic signed [W-1:0] r;
        a = W'(x);
        if (x[BITS-1]) a = -a;
        if (a >= C_5)
            r = C_ONE;
        else if (a >= C_2375)
            r = ((S_32 * a) >>> FRAC) + C_27;
        else if (a >= C_ONE)
            r = ((S_8 * a) >>> FRAC) + C_58;
        else
            r = ((S_4 * a) >>> FRAC) + C_HALF;
        if (x[BITS-1]) r = C_ONE - r;
        return BITS'(r);
    endfunction

    logic [1:0]             state;
    logic signed [BITS-1:0] lo;
    logic signed [BITS-1:0] hi;
    logic signed [BITS-1:0] y_q;
    logic [CW-1:0]          cnt;
    logic                   err_q;

    logic signed [BITS:0]   sum;
    logic signed [BITS-1:0] mid;
    logic signed [BITS-1:0] f_arg;
    logic signed [BITS-1:0] f_val;
    logic                   y_lt0;
    logic                   y_le0;
    logic                   y_gt1;

    assign sum   = {lo[BITS-1], lo} + {hi[BITS-1], hi};
    assign mid   = BITS'(sum >>> 1);
    // One evaluator serves both the search probe and the DONE result.
    assign f_arg = (state == DONE) ? lo : mid;
    assign f_val = f_eval(f_arg);

    assign y_lt0 = bus.in_y[BITS-1];
    assign y_le0 = y_lt0 || (bus.in_y == '0);
    assign y_gt1 = $signed(bus.in_y) > Y_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lo    <= '0;
            hi    <= '0;
            y_q   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        y_q   <= $signed(bus.in_y);
                        err_q <= y_lt0 || y_gt1;
                        lo    <= LO0;
                        hi    <= HI0;
                        cnt   <= '0;
                        state <= SEARCH;
`ifdef SIGINV_FASTPATH_EN
                        if (y_le0) begin
                            hi    <= LO0;
                            state <= DONE;
                        end else if (y_gt1) begin
                            lo    <= HI0;
                            state <= DONE;
                        end
`endif
                    end
                end
                SEARCH: begin
                    if (f_val >= y_q)
                        hi <= mid;
                    else
                        lo <= mid + 1'b1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1))
                        state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SIGINV_FASTPATH_EN
    logic unused_y_le0;
    assign unused_y_le0 = y_le0;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_x     = (state == DONE) ? lo : '0;
    assign bus.out_fx    = (state == DONE) ? f_val : '0;
    assign bus.out_err   = (state == DONE) && err_q;
endmodule

// File: tb/tb_sigmoid_inverse_search.sv
// Directed bench for sigmoid_inverse_search against an exhaustive-scan model of the inverse.
module tb_sigmoid_inverse_search;
    localparam int BITS = 16;
    localparam int FRAC = 8;
    localparam int ONE  = 256;
    localparam int LO0  = -2048;
    localparam int HI0  = 2047;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sigmoid_inverse_search_if #(.BITS(BITS)) bus ();
    sigmoid_inverse_search #(.BITS(BITS), .FRAC(FRAC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_x = 0;
    int exp_fx = 0;
    int exp_err = 0;
    bit armed = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int fp_m(input int a);
        if (a >= 5 * ONE)       return ONE;
        if (8 * a >= 19 * ONE)  return (((ONE / 32) * a) >> FRAC) + 27 * ONE / 32;
        if (a >= ONE)           return (((ONE / 8) * a) >> FRAC) + 5 * ONE / 8;
        return (((ONE / 4) * a) >> FRAC) + ONE / 2;
    endfunction

    function automatic int fm(input int x);
        return (x >= 0) ? fp_m(x) : ONE - fp_m(-x);
    endfunction

    // Linear scan over the whole range: the smallest x reaching y, or the top of the range.
    function automatic int model_x(input int y);
        for (int x = LO0; x <= HI0; x++)
            if (fm(x) >= y) return x;
        return HI0;
    endfunction

    always @(negedge clk) begin
        if (rst_n && armed && bus.out_valid) begin
            chk("out_x", int'($signed(bus.out_x)), exp_x);
            chk("out_fx", int'($signed(bus.out_fx)), exp_fx);
            chk("out_err", int'(bus.out_err), exp_err);
            chk("in_ready_in_done", int'(bus.in_ready), 0);
        end
    end

    task automatic run_req(input logic [15:0] y, input int hold, input bit pulse, input bit both);
        int yi;
        int lat;
        int exp_lat;
        int t;
        yi = int'($signed(y));
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk("in_ready_wait", 0, 1);
        exp_x   = model_x(yi);
        exp_fx  = fm(exp_x);
        exp_err = (yi < 0 || yi > ONE) ? 1 : 0;
        exp_lat = 13;
`ifdef SIGINV_FASTPATH_EN
        if (yi <= 0 || yi > ONE) exp_lat = 1;
`endif
        armed = 1'b1;
        bus.in_y = y;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        for (int k = 0; k < hold; k++) begin
            if (pulse && k == 1) begin
                bus.in_y = 16'h0100;
                bus.in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_in_ready", int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        if (both) begin
            bus.in_y = 16'h0040;
            bus.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        armed = 1'b0;
        chk("in_ready_after_accept", int'(bus.in_ready), 1);
        chk("out_valid_after_accept", int'(bus.out_valid), 0);
        if (both) begin
            @(posedge clk);
            #1;
            chk("no_take_on_accept", int'(bus.in_ready), 1);
        end
    endtask

    logic [15:0] ys [9] = '{16'h0080, 16'h00C0, 16'h0100, 16'h0000, 16'h0101,
                            16'hFF80, 16'h0001, 16'h00FF, 16'h0040};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;

        chk("pin_f_00ff", fm(255), 191);
        chk("pin_f_0100", fm(256), 192);
        chk("pin_f_04ff", fm(1279), 255);
        chk("pin_f_m3", fm(-3), 128);
        chk("pin_x_0080", model_x(128), -3);
        chk("pin_x_00c0", model_x(192), 256);
        chk("pin_x_0100", model_x(256), 1280);
        chk("pin_x_0000", model_x(0), LO0);
        chk("pin_x_0101", model_x(257), HI0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_out_x", int'(bus.out_x), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", int'(bus.in_ready), 1);

        // Abort a search part way through with reset.
        bus.in_y = 16'h0080;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_search_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_x", int'(bus.out_x), 0);
        chk("rst_out_fx", int'(bus.out_fx), 0);
        chk("rst_out_err", int'(bus.out_err), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_out_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_in_ready", int'(bus.in_ready), 1);

        for (int i = 0; i < 9; i++)
            run_req(ys[i], 0, 1'b0, 1'b0);

        run_req(16'h00C0, 5, 1'b1, 1'b0);
        run_req(16'h0101, 3, 1'b0, 1'b1);
        run_req(16'h0080, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sigmoid_inverse_search.md
Name: sigmoid_inverse_search

Overview:
- Sequential inverse of the piecewise-linear sigmoid: given a target activation y, returns the smallest x with f(x) >= y. It does this by bisection, evaluating f once per clock.
- Signed fixed point, BITS total, FRAC fractional.
- Sits on the decode side of the activation path: recovers the pre-activation value from a stored alfa for the VAE latent-space sampler.
- Contains its own copy of the segment coefficients, so the result matches the forward evaluator bit-exactly.

Parameters:
- BITS, 16, word width of y, x and f(x); two's complement.
- FRAC, 8, fractional bits. Constraints: FRAC >= 5 and BITS >= FRAC+5.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- in_y  in  BITS  target activation (signed Q)
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- out_x  out  BITS  smallest x in search range with f(x) >= in_y
- out_fx  out  BITS  f(out_x)
- out_err  out  1  in_y < 0 or in_y > 1.0; out_x is still the search result

Behaviour:
- Forward function, with ONE = 2^FRAC and a = |x| computed at BITS+1 width:
  - Positive half, fp(a):
    - a >= 5.0 → ONE
    - 2.375 <= a < 5.0 → ((ONE/32)*a >>> FRAC) + 27*ONE/32
    - 1.0 <= a < 2.375 → ((ONE/8)*a >>> FRAC) + 5*ONE/8
    - a < 1.0 → ((ONE/4)*a >>> FRAC) + ONE/2
  - Thresholds are scaled by ONE. Product is 2*BITS wide, shifted arithmetically (floor).
  - f(x) = fp(x) for x >= 0; f(x) = ONE - fp(-x) for x < 0.
- Search range: lo0 = -8.0 = -2^(FRAC+3), hi0 = 8.0 - 1 lsb. ITER = FRAC+4 (12 at default).
- States:
  - IDLE: in_ready=1.
    - On in_valid: latch y, set lo=lo0, hi=hi0, cnt=0, go to SEARCH.
  - SEARCH, one step per cycle:
    - mid = (lo+hi) >>> 1, computed at BITS+1 width.
    - If f(mid) >= y: hi = mid; else lo = mid+1.
    - cnt++. When cnt == ITER-1 this cycle, go to DONE.
  - DONE:
    - out_x = lo, out_fx = f(lo), out_valid = 1; outputs stable while out_valid and !out_ready.
    - On out_ready: return to IDLE.
- Latency: the handshake cycle plus ITER SEARCH cycles. out_valid rises exactly ITER+1 clocks after in_valid is accepted (13 at default).
- The range size is a power of two, so exactly ITER steps always converge to lo == hi.
- out_err is computed when y is latched.
  - y > ONE: no x satisfies f >= y; result is hi0 (0x07FF), out_fx = ONE.
  - y <= 0: result is lo0 (0xF800).
- in_valid outside IDLE is ignored; no queuing.
- rst_n low at any time, including mid-SEARCH or in DONE:
  - state → IDLE; out_valid=0, out_x=0, out_fx=0, out_err=0; in_ready=1 one clock after rst_n deasserts.
  - A partial search is discarded.
- Simultaneous out_ready and in_valid in DONE: the result is accepted, and the new request is NOT taken that cycle (in_ready=0).

Optional Feature:
- Macro SIGINV_FASTPATH_EN.
- Defined:
  - In IDLE, a request with y <= 0 or y > ONE skips SEARCH and goes straight to DONE.
  - out_x = lo0 or hi0 respectively; out_valid rises 1 clock after the handshake.
  - Results identical to the non-fastpath build.
- Undefined: every request takes ITER+1 cycles.

Test Plan:
- Reset check: reset asserted mid-SEARCH → next cycle out_valid=0, out_x=0; after release in_ready=1, and a new y=0x0080 completes normally.
- y=0x0080 (0.5) → out_x=0xFFFD, out_fx=0x0080, out_err=0, out_valid 13 clocks after handshake.
- y=0x00C0 (0.75) → out_x=0x0100, out_fx=0x00C0. Also checks the segment boundary: f(0x00FF)=0x00BF.
- y=0x0100 (1.0) → out_x=0x0500, out_fx=0x0100. Also checks f(0x04FF)=0x00FF.
- Range edges:
  - y=0x0000 → out_x=0xF800, out_fx=0x0000, out_err=0.
  - y=0x0101 → out_x=0x07FF, out_fx=0x0100, out_err=1.
  - y=0xFF80 → out_x=0xF800, out_err=1.
  - With SIGINV_FASTPATH_EN, the two out_err cases complete in 1 clock.
- Backpressure: hold out_ready=0 for 5 cycles → out_x/out_fx stable, in_ready=0, and an in_valid pulse during DONE is dropped. Then raise out_ready → IDLE next cycle.
